// File: rtl/ray_dispatcher.sv
// ray_dispatcher: single-entry ray buffer issued round-robin to ready units
module ray_dispatcher #(
    parameter int POSITION_WIDTH = 16,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int UNITS          = 4,
    parameter int COUNT_WIDTH    = 24
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        inStart,
    input  logic [3*POSITION_WIDTH-1:0] inRayV,
    input  logic [ADDRESS_WIDTH-1:0]    inAddress,
    output logic                        inReady,
    output logic                        inBusy,
    output logic [UNITS-1:0]            outStart,
    output logic [3*POSITION_WIDTH-1:0] outRayV,
    output logic [ADDRESS_WIDTH-1:0]    outAddress,
    input  logic [UNITS-1:0]            unitReady,
    input  logic [UNITS-1:0]            unitBusy,
    output logic [COUNT_WIDTH-1:0]      dispatched
);
    localparam int RW = 3 * POSITION_WIDTH;
    localparam int PW = $clog2(UNITS);
    localparam int LI = UNITS - 1;
    localparam logic [PW:0]   UN   = UNITS[PW:0];
    localparam logic [PW-1:0] LAST = LI[PW-1:0];
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state_q, state_d;
    logic [RW-1:0] buf_ray_q, buf_ray_d, out_ray_q, out_ray_d;
    logic [ADDRESS_WIDTH-1:0] buf_addr_q, buf_addr_d, out_addr_q, out_addr_d;
    logic [UNITS-1:0] out_start_q, out_start_d, elig;
    logic [PW-1:0] ptr_q, ptr_d, grant;
    logic [PW:0] sum, idx;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic hit;
    // the unit pulsed last cycle is masked because its ready drop lags by one cycle
    always_comb begin
        elig  = unitReady & ~out_start_q;
        hit   = |elig;
        grant = '0;
        sum   = '0;
        idx   = '0;
        for (int k = UNITS - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + k[PW:0];
            idx = (sum >= UN) ? sum - UN : sum;
            if (elig[idx[PW-1:0]]) grant = idx[PW-1:0];
        end
    end
    // buffer state machine, issue and counter; flush overrides everything
    always_comb begin
        state_d     = state_q;
        buf_ray_d   = buf_ray_q;
        buf_addr_d  = buf_addr_q;
        out_start_d = '0;
        out_ray_d   = out_ray_q;
        out_addr_d  = out_addr_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        if (flush) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else if (state_q == EMPTY) begin
            if (inStart) begin
                state_d    = FULL;
                buf_ray_d  = inRayV;
                buf_addr_d = inAddress;
            end
        end else if (hit) begin
            state_d     = EMPTY;
            out_start_d = {{(UNITS-1){1'b0}}, 1'b1} << grant;
            out_ray_d   = buf_ray_q;
            out_addr_d  = buf_addr_q;
            ptr_d       = (grant == LAST) ? '0 : grant + 1'b1;
            cnt_d       = cnt_q + 1'b1;
        end
    end
    // state registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            buf_ray_q   <= '0;
            buf_addr_q  <= '0;
            out_start_q <= '0;
            out_ray_q   <= '0;
            out_addr_q  <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            buf_ray_q   <= buf_ray_d;
            buf_addr_q  <= buf_addr_d;
            out_start_q <= out_start_d;
            out_ray_q   <= out_ray_d;
            out_addr_q  <= out_addr_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end
    assign inReady    = (state_q == EMPTY);
    assign inBusy     = (state_q == FULL) | (|out_start_q) | (|unitBusy);
    assign outStart   = out_start_q;
    assign outRayV    = out_ray_q;
    assign outAddress = out_addr_q;
    assign dispatched = cnt_q;
endmodule

// File: tb/tb_ray_dispatcher.sv
// tb_ray_dispatcher: directed self-checking bench for ray_dispatcher
module tb_ray_dispatcher;
    logic        clock = 0;
    logic        reset = 0;
    logic        flush = 0;
    logic        inStart = 0;
    logic [47:0] inRayV = '0;
    logic [31:0] inAddress = '0;
    logic        inReady, inBusy;
    logic [3:0]  outStart;
    logic [47:0] outRayV;
    logic [31:0] outAddress;
    logic [3:0]  unitReady = '0;
    logic [3:0]  unitBusy = '0;
    logic [23:0] dispatched;
    int vectors = 0;
    int fails = 0;
    ray_dispatcher dut (
        .clock(clock), .reset(reset), .flush(flush), .inStart(inStart),
        .inRayV(inRayV), .inAddress(inAddress), .inReady(inReady), .inBusy(inBusy),
        .outStart(outStart), .outRayV(outRayV), .outAddress(outAddress),
        .unitReady(unitReady), .unitBusy(unitBusy), .dispatched(dispatched)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    // offer one ray, then wait for the issue edge
    task automatic send(input logic [31:0] a);
        inStart = 1;
        inAddress = a;
        inRayV = {16'h1111, a[15:0], 16'h3333};
        step();
        inStart = 0;
        step();
    endtask
    initial begin
        #12 reset = 1;
        step();
        check("rst_ready", inReady, 1);
        check("rst_busy", inBusy, 0);
        check("rst_start", outStart, 0);
        check("rst_cnt", dispatched, 0);
        unitReady = 4'b1111;
        send(32'h100);
        check("single_start", outStart, 4'b0001);
        check("single_addr", outAddress, 32'h100);
        check("single_ray", outRayV, {16'h1111, 16'h0100, 16'h3333});
        check("single_cnt", dispatched, 1);
        check("single_busy", inBusy, 1);
        #1 reset = 0;
        #1;
        check("async_start", outStart, 0);
        check("async_cnt", dispatched, 0);
        check("async_ready", inReady, 1);
        check("async_busy", inBusy, 0);
        #2 reset = 1;
        step();
        send(32'h200);
        check("rr0", outStart, 4'b0001);
        send(32'h201);
        check("rr1", outStart, 4'b0010);
        send(32'h202);
        check("rr2", outStart, 4'b0100);
        send(32'h203);
        check("rr3", outStart, 4'b1000);
        check("rr3_addr", outAddress, 32'h203);
        send(32'h204);
        check("rr4", outStart, 4'b0001);
        check("rr_cnt", dispatched, 5);
        step();
        check("pulse_one_cycle", outStart, 0);
        check("addr_hold", outAddress, 32'h204);
        unitReady = 4'b0010;
        send(32'h300);
        check("to_ptr2", outStart, 4'b0010);
        unitReady = 4'b0011;
        send(32'h301);
        check("skip_wrap", outStart, 4'b0001);
        unitReady = 4'b0001;
        send(32'h302);
        check("wrap_only0", outStart, 4'b0001);
        check("wrap_cnt", dispatched, 8);
        unitReady = 4'b0000;
        inStart = 1;
        inAddress = 32'hA;
        step();
        check("bp_ready", inReady, 0);
        inAddress = 32'hB;
        step();
        check("bp_hold_ready", inReady, 0);
        check("bp_no_start", outStart, 0);
        check("bp_cnt", dispatched, 8);
        unitReady = 4'b1000;
        step();
        check("bp_start", outStart, 4'b1000);
        check("bp_addr_a", outAddress, 32'hA);
        check("bp_ready_back", inReady, 1);
        step();
        inStart = 0;
        check("bp_take_b", inReady, 0);
        check("bp_gap", outStart, 0);
        step();
        check("bp_start_b", outStart, 4'b1000);
        check("bp_addr_b", outAddress, 32'hB);
        check("bp_cnt2", dispatched, 10);
        unitReady = 4'b0000;
        inStart = 1;
        inAddress = 32'hC;
        step();
        inStart = 0;
        check("fl_full", inReady, 0);
        check("fl_busy", inBusy, 1);
        flush = 1;
        inStart = 1;
        inAddress = 32'hD;
        unitReady = 4'b1111;
        step();
        flush = 0;
        inStart = 0;
        check("fl_ready", inReady, 1);
        check("fl_busy0", inBusy, 0);
        check("fl_cnt", dispatched, 0);
        check("fl_nostart", outStart, 0);
        step();
        check("fl_nostart2", outStart, 0);
        check("fl_addr_kept", outAddress, 32'hB);
        unitBusy = 4'b0100;
        #1;
        check("unit_busy", inBusy, 1);
        unitBusy = 4'b0000;
        send(32'h400);
        check("fl_ptr_kept", outStart, 4'b0001);
        check("fl_cnt1", dispatched, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
